// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states and
// framing constants of the serial load stream.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  // Width of the little-endian word-count header.
  localparam int HDR_WIDTH      = 16;
  // Stream bytes making up one instruction word.
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_WIDTH     = 32;

endpackage

// File: rtl/word_assembler.sv
// Collects stream bytes into 32-bit little-endian words: the first byte of a
// word lands in bits [7:0] once all four bytes have been shifted in.
module word_assembler
  import loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  shift_en,
  input  logic [7:0]            byte_in,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  word_done
);

  logic [1:0]            cnt_reg;
  logic [WORD_WIDTH-1:0] word_reg;

  // Shift each accepted byte in from the top so the earliest byte ends lowest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg  <= '0;
      word_reg <= '0;
    end else if (clear) begin
      cnt_reg  <= '0;
    end else if (shift_en) begin
      word_reg <= {byte_in, word_reg[WORD_WIDTH-1:8]};
      cnt_reg  <= cnt_reg + 2'd1;
    end
  end

  // The fourth byte is being accepted this cycle; the word is complete next cycle.
  always_comb begin
    word_done = shift_en && !clear && (cnt_reg == 2'(BYTES_PER_WORD - 1));
  end

  assign word = word_reg;

endmodule

// File: rtl/imem_loader.sv
// Serial instruction-memory loader: receives a 16-bit word count followed by
// that many little-endian 32-bit words and writes them to consecutive
// addresses, holding the CPU in reset until the load completes.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err
);

  // One extra bit so an index of DEPTH can be compared without wrapping.
  localparam int IDX_WIDTH = ADDR_WIDTH + 1;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  state_t                 state_reg, state_next;
  logic [HDR_WIDTH-1:0]   len_reg, len_next;
  logic [IDX_WIDTH-1:0]   idx_reg, idx_next;
  logic [ADDR_WIDTH-1:0]  addr_hold_reg;
  logic [WORD_WIDTH-1:0]  data_hold_reg;

  logic                   accept;
  logic                   asm_clear;
  logic                   asm_shift;
  logic                   word_done;
  logic [WORD_WIDTH-1:0]  asm_word;
  logic [HDR_WIDTH-1:0]   hdr_word;
  logic [IDX_WIDTH-1:0]   idx_inc;

  assign accept   = byte_valid && byte_ready;
  assign hdr_word = {byte_in, len_reg[7:0]};
  assign idx_inc  = idx_reg + 1'b1;

  word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (asm_clear),
    .shift_en  (asm_shift),
    .byte_in   (byte_in),
    .word      (asm_word),
    .word_done (word_done)
  );

  // State, header and word-index registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      len_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      idx_reg   <= idx_next;
    end
  end

  // Remember the last written address/data so the ports hold outside WRITE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_hold_reg <= '0;
      data_hold_reg <= '0;
    end else if (state_reg == WRITE) begin
      addr_hold_reg <= idx_reg[ADDR_WIDTH-1:0];
      data_hold_reg <= asm_word;
    end
  end

  // Next-state logic and per-state handshake/write strobes.
  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    idx_next   = idx_reg;
    asm_clear  = 1'b0;
    asm_shift  = 1'b0;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next = LEN_LO;
          asm_clear  = 1'b1;
        end
      end
      LEN_LO: begin
        byte_ready = 1'b1;
        if (accept) begin
          len_next[7:0] = byte_in;
          state_next    = LEN_HI;
        end
      end
      LEN_HI: begin
        byte_ready = 1'b1;
        if (accept) begin
          len_next = hdr_word;
          if (hdr_word == '0) begin
            state_next = DONE;
          end else if (32'(hdr_word) > 32'(DEPTH)) begin
            state_next = ERR;
          end else begin
            state_next = DATA;
            idx_next   = '0;
            asm_clear  = 1'b1;
          end
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        asm_shift  = accept;
        if (word_done) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        wr_en    = 1'b1;
        idx_next = idx_inc;
        if (HDR_WIDTH'(idx_inc) == len_reg) begin
          state_next = DONE;
        end else begin
          state_next = DATA;
        end
      end
      ERR: begin
        // Drain the rest of a rejected stream so the source never stalls.
        byte_ready = 1'b1;
        if (start) begin
          state_next = LEN_LO;
          asm_clear  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign wr_addr  = (state_reg == WRITE) ? idx_reg[ADDR_WIDTH-1:0] : addr_hold_reg;
  assign wr_data  = (state_reg == WRITE) ? asm_word : data_hold_reg;
  assign cpu_hold = (state_reg != DONE);
  assign done     = (state_reg == DONE);
  assign err      = (state_reg == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as words are
// sent and compared when the loader strobes wr_en.
module tb_imem_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_hold;
  logic          done;
  logic          err;

  int tests_run    = 0;
  int tests_failed = 0;
  int wr_count     = 0;

  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] exp_e;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: pop the scoreboard on every write strobe.
  always @(negedge clk) begin
    if (rst && wr_en) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", 32'(wr_addr), 32'hFFFF_FFFF);
      end else begin
        exp_e = exp_q.pop_front();
        $display("[TB] write addr=%0d data=0x%08h", wr_addr, wr_data);
        chk("wr_addr", 32'(wr_addr), 32'(exp_e[AW+31:32]));
        chk("wr_data", wr_data, exp_e[31:0]);
      end
    end
  end

  // Present one byte and wait until it has been accepted; called and returns at a negedge.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
        @(negedge clk);
      end
    end
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'(byte_ready), 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [AW-1:0] a, input logic [31:0] d, input bit gaps);
    exp_q.push_back({a, d});
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], gaps);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Last byte has just been taken: wr_en now, done on the next cycle.
  task automatic check_finish(input string tag);
    chk({tag, "_wr_lat"}, 32'(wr_en), 32'd1);
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
  endtask

  int wc;

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Reset state, and nothing happens without start.
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_data", wr_data, 32'd0);
    repeat (5) @(negedge clk);
    chk("idle_no_wr", 32'(wr_count), 32'd0);

    // Two-word load.
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(8'd0, 32'h0050_0013, 1'b0);
    send_word(8'd1, 32'h0010_8093, 1'b0);
    check_finish("two_word");
    chk("two_word_cnt", 32'(wr_count), 32'd2);

    // Restart from DONE, then an empty load.
    pulse_start();
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_no_wr", 32'(wr_count), 32'd2);

    // Oversized header: error, bytes drained, no writes; start recovers.
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    chk("err_flag", 32'(err), 32'd1);
    chk("err_hold", 32'(cpu_hold), 32'd1);
    chk("err_ready", 32'(byte_ready), 32'd1);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
    chk("err_stay", 32'(err), 32'd1);
    chk("err_no_wr", 32'(wr_count), 32'd2);
    pulse_start();
    chk("err_clear", 32'(err), 32'd0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(8'd0, 32'hDEAD_BEEF, 1'b0);
    check_finish("err_recover");

    // Gappy byte_valid, start pulsed mid-word.
    pulse_start();
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    exp_q.push_back({8'd0, 32'h0050_0013});
    send_byte(8'h13, 1'b1);
    send_byte(8'h00, 1'b1);
    pulse_start();
    send_byte(8'h50, 1'b1);
    send_byte(8'h00, 1'b1);
    send_word(8'd1, 32'h0010_8093, 1'b1);
    check_finish("gappy");
    chk("gappy_cnt", 32'(wr_count), 32'd5);

    // Full-depth load: N = DEPTH, last write to DEPTH-1.
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    for (int i = 0; i < (1 << AW); i++) send_word(AW'(i), $urandom, 1'b0);
    check_finish("full");
    chk("full_last_addr", 32'(wr_addr), 32'((1 << AW) - 1));
    chk("full_cnt", 32'(wr_count), 32'(5 + (1 << AW)));

    // Reset in the middle of word 1 abandons the session.
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(8'd0, 32'h1234_5678, 1'b0);
    @(negedge clk);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    wc = wr_count;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(byte_ready), 32'd0);
    chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_wr", 32'(wr_en), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("mid_rst_no_wr", 32'(wr_count), 32'(wc));
    chk("mid_rst_idle", 32'(byte_ready), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, giving the instruction memory word-address width; DEPTH = 2^ADDR_WIDTH words.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 start  input  1  single-cycle pulse that begins a load session.
REQ-006 byte_in  input  8  serial load stream byte.
REQ-007 byte_valid  input  1  byte_in holds a valid byte.
REQ-008 byte_ready  output  1  block accepts byte_in this cycle.
REQ-009 wr_en  output  1  instruction-memory write strobe.
REQ-010 wr_addr  output  ADDR_WIDTH  word address of the write.
REQ-011 wr_data  output  32  instruction word to write.
REQ-012 cpu_hold  output  1  holds the CPU (PC and register file) in reset while high.
REQ-013 done  output  1  load completed successfully.
REQ-014 err  output  1  length header exceeds DEPTH.

Function
REQ-015 A byte SHALL transfer only on a cycle where byte_valid and byte_ready are both high; the byte source holds byte_in stable until the transfer occurs.
REQ-016 States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
REQ-017 IDLE: byte_ready=0; start moves to LEN_LO.
REQ-018 LEN_LO and LEN_HI: byte_ready=1; each accepted byte forms a 16-bit little-endian word count N, then moves to the next state.
REQ-019 After LEN_HI: N=0 SHALL go to DONE; N>DEPTH SHALL go to ERR; otherwise go to DATA with word index cleared to 0.
REQ-020 DATA: byte_ready=1; four accepted bytes SHALL be assembled little-endian (first byte into bits [7:0]); on the fourth byte go to WRITE.
REQ-021 WRITE lasts exactly one cycle: wr_en=1, wr_addr=word index, wr_data=assembled word, byte_ready=0.
REQ-022 After WRITE, the word index SHALL increment; if the new index equals N go to DONE, else go to DATA.
REQ-023 Latency: the last byte of a word accepted in cycle t gives wr_en high in cycle t+1; after the final word, done goes high in cycle t+2.
REQ-024 wr_en SHALL be 0 in every state except WRITE; wr_addr and wr_data SHALL hold their last value outside WRITE.
REQ-025 DONE: done=1, cpu_hold=0, byte_ready=0; start returns to LEN_LO with done=0 and cpu_hold=1 in the following cycle.
REQ-026 ERR: err=1, cpu_hold=1, byte_ready=1 (discard every byte); no writes occur; only start leaves ERR (to LEN_LO, clearing err).
REQ-027 start SHALL be ignored in LEN_LO, LEN_HI, DATA and WRITE.
REQ-028 cpu_hold SHALL be 1 in every state except DONE.
REQ-029 N=DEPTH is legal: the final write goes to address DEPTH-1, and the word index is wide enough not to wrap before the compare.

Reset
REQ-030 When rst goes low, state SHALL go to IDLE and the outputs SHALL take these values: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, err=0; the word index and byte counter SHALL clear.
REQ-031 A reset during a session SHALL abandon it with no further writes; memory already written is not scrubbed.

Structure
REQ-032 A shared package loader_pkg SHALL hold the state enum, the 16-bit header width constant and BYTES_PER_WORD=4.
REQ-033 One sub-module, word_assembler, SHALL hold the 2-bit byte counter and the 32-bit shift register and flag word completion.

Verification
REQ-034 Reset with no stimulus -> cpu_hold=1, done=0, byte_ready=0, wr_en never high.
REQ-035 start, then bytes 02 00 13 00 50 00 93 80 10 00 -> wr_en at addr 0 with 0x00500013, then at addr 1 with 0x00108093; done=1 and cpu_hold=0 two cycles after the last byte.
REQ-036 Header 00 00 -> DONE directly, no wr_en pulse.
REQ-037 With ADDR_WIDTH=8, header 01 01 (N=257) -> err=1, no writes, bytes still accepted; a later start with a valid load clears err.
REQ-038 byte_valid toggled randomly mid-word, and start pulsed during DATA -> identical writes to REQ-035; start has no effect.
REQ-039 rst asserted after two data bytes of word 1 -> IDLE immediately, no write to addr 1, cpu_hold=1.
